// File: rtl/vec_mem_seq.sv
// vec_mem_seq - multi-cycle sequencer for vector memory instructions
// (vldr / vstr) on the SIMD AES core.
//
// One 128-bit vector register transfer is split into LANES word accesses on
// the shared 32-bit data-memory port. The pipeline is stalled while the
// transfer runs. Loads finish with a single vector register-file write strobe.
//
// Optional build macro:
//   VMEM_TIMEOUT_EN - when defined, a per-lane wait counter abandons the
//                     transfer after TIMEOUT_CYC cycles without mem_ack and
//                     pulses err. When undefined, err is tied to 0 and XFER
//                     waits indefinitely for mem_ack.
//
// Ports:
//   clk, rst_n   clock; synchronous active-low reset
//   start        vector memory instruction present in execute
//   is_store     1 = vstr, 0 = vldr (sampled with start)
//   base_addr    lane-0 byte address (sampled with start)
//   vec_wdata    store vector, lane i at [i*LANE_W +: LANE_W] (sampled with start)
//   mem_req      memory access request
//   mem_we       write enable, valid while mem_req=1
//   mem_addr     current lane address
//   mem_wdata    current lane store data
//   mem_rdata    load data, valid when mem_ack=1
//   mem_ack      access completes this cycle
//   stall        hold PC and pipeline registers
//   vreg_we      one-cycle vector register-file write strobe
//   vec_rdata    assembled load vector
//   done         one-cycle completion pulse
//   err          one-cycle timeout pulse

module vec_mem_seq #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned LANE_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*LANE_W-1:0] vec_wdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  input  logic [LANE_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic                    stall,
  output logic                    vreg_we,
  output logic [LANES*LANE_W-1:0] vec_rdata,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned LANE_CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_WB,
    S_FIN
  } state_e;

  state_e                          state_q, state_d;
  logic [LANE_CW-1:0]              lane_q, lane_d;
  logic                            store_q, store_d;
  logic [ADDR_W-1:0]               base_q, base_d;
  logic [LANES-1:0][LANE_W-1:0]    wdata_q, wdata_d;
  logic [LANES-1:0][LANE_W-1:0]    rdata_q, rdata_d;
  logic                            timed_out;

`ifdef VMEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  assign timed_out = (wait_q == WAIT_W'(TIMEOUT_CYC));
  assign err       = (state_q == S_XFER) && timed_out;

  // Counter is zero outside XFER, so it is already clear for each new
  // transfer; an ack restarts the count for the next lane.
  always_comb begin
    wait_d = '0;
    if ((state_q == S_XFER) && !timed_out && !mem_ack) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  assign vec_rdata = rdata_q;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    store_d   = store_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    vreg_we   = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Hold the instruction in execute in the very cycle it appears.
        stall = start;
        if (start) begin
          store_d = is_store;
          base_d  = base_addr;
          wdata_d = vec_wdata;
          lane_d  = '0;
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        if (timed_out) begin
          // Abandon the transfer: request dropped, pipeline released,
          // no write-back and no done.
          lane_d  = '0;
          state_d = S_IDLE;
        end else begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = store_q;
          mem_addr  = base_q + ADDR_W'(lane_q) * ADDR_W'(ADDR_STRIDE);
          mem_wdata = wdata_q[lane_q];
          if (mem_ack) begin
            if (!store_q) begin
              rdata_d[lane_q] = mem_rdata;
            end
            if (lane_q == LAST_LANE) begin
              lane_d  = '0;
              state_d = store_q ? S_FIN : S_WB;
            end else begin
              lane_d = lane_q + LANE_CW'(1);
            end
          end
        end
      end

      S_WB: begin
        vreg_we = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      store_q <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      store_q <= store_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
module tb_vec_mem_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_store;
  logic [31:0]  base_addr;
  logic [127:0] vec_wdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ack;
  logic         stall;
  logic         vreg_we;
  logic [127:0] vec_rdata;
  logic         done;
  logic         err;

  int errors = 0;
  int checks = 0;

  vec_mem_seq #(
    .LANES(4),
    .LANE_W(32),
    .ADDR_W(32),
    .ADDR_STRIDE(4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .is_store(is_store),
    .base_addr(base_addr),
    .vec_wdata(vec_wdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .stall(stall),
    .vreg_we(vreg_we),
    .vec_rdata(vec_rdata),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: four known words at 0x100..0x10C, an address-derived
  // pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_word = 32'h1111_1111;
      32'h0000_0104: mem_word = 32'h2222_2222;
      32'h0000_0108: mem_word = 32'h3333_3333;
      32'h0000_010C: mem_word = 32'h4444_4444;
      default:       mem_word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  typedef struct {
    logic         st;
    logic         str;
    logic [31:0]  base;
    logic [127:0] wd;
    logic         e_req;
    logic         e_we;
    logic [31:0]  e_addr;
    logic [31:0]  e_mwd;
    logic         e_stall;
    logic         e_vwe;
    logic         e_done;
    logic [127:0] e_vr;
  } vec_t;

  function automatic vec_t mk(
    input logic st, input logic str, input logic [31:0] base, input logic [127:0] wd,
    input logic rq, input logic we, input logic [31:0] ad, input logic [31:0] mwd,
    input logic sl, input logic vw, input logic dn, input logic [127:0] vr);
    vec_t r;
    r.st = st; r.str = str; r.base = base; r.wd = wd;
    r.e_req = rq; r.e_we = we; r.e_addr = ad; r.e_mwd = mwd;
    r.e_stall = sl; r.e_vwe = vw; r.e_done = dn; r.e_vr = vr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] V1   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] WST  = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
  localparam logic [127:0] VWR  = 128'h5A5A0004_5A5A0000_A5A5FFFC_A5A5FFF8;
  localparam logic [127:0] WWS  = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;

  vec_t tbl [18];

  initial begin
    // load 0x100, back-to-back store 0x200, back-to-back wrapping load
    tbl[0]  = mk(1, 0, 32'h100, '0,  0, 0, 32'h0,   32'h0, 1, 0, 0, '0);
    tbl[1]  = mk(0, 0, 32'h0,   '0,  1, 0, 32'h100, 32'h0, 1, 0, 0, '0);
    tbl[2]  = mk(0, 0, 32'h0,   '0,  1, 0, 32'h104, 32'h0, 1, 0, 0, 128'h11111111);
    tbl[3]  = mk(0, 0, 32'h0,   '0,  1, 0, 32'h108, 32'h0, 1, 0, 0, 128'h22222222_11111111);
    tbl[4]  = mk(0, 0, 32'h0,   '0,  1, 0, 32'h10C, 32'h0, 1, 0, 0, 128'h33333333_22222222_11111111);
    tbl[5]  = mk(0, 0, 32'h0,   '0,  0, 0, 32'h0,   32'h0, 0, 1, 1, V1);
    tbl[6]  = mk(1, 1, 32'h200, WST, 0, 0, 32'h0,   32'h0, 1, 0, 0, V1);
    tbl[7]  = mk(0, 0, 32'h0,   '0,  1, 1, 32'h200, 32'h89ABCDEF, 1, 0, 0, V1);
    tbl[8]  = mk(0, 0, 32'h0,   '0,  1, 1, 32'h204, 32'h01234567, 1, 0, 0, V1);
    tbl[9]  = mk(0, 0, 32'h0,   '0,  1, 1, 32'h208, 32'hCAFEBABE, 1, 0, 0, V1);
    tbl[10] = mk(0, 0, 32'h0,   '0,  1, 1, 32'h20C, 32'hDEADBEEF, 1, 0, 0, V1);
    tbl[11] = mk(0, 0, 32'h0,   '0,  0, 0, 32'h0,   32'h0, 0, 0, 1, V1);
    tbl[12] = mk(1, 0, 32'hFFFFFFF8, '0, 0, 0, 32'h0, 32'h0, 1, 0, 0, V1);
    tbl[13] = mk(0, 0, 32'h0,   '0,  1, 0, 32'hFFFFFFF8, 32'h0, 1, 0, 0, V1);
    tbl[14] = mk(0, 0, 32'h0,   '0,  1, 0, 32'hFFFFFFFC, 32'h0, 1, 0, 0,
                 128'h44444444_33333333_22222222_A5A5FFF8);
    tbl[15] = mk(0, 0, 32'h0,   '0,  1, 0, 32'h00000000, 32'h0, 1, 0, 0,
                 128'h44444444_33333333_A5A5FFFC_A5A5FFF8);
    tbl[16] = mk(0, 0, 32'h0,   '0,  1, 0, 32'h00000004, 32'h0, 1, 0, 0,
                 128'h44444444_5A5A0000_A5A5FFFC_A5A5FFF8);
    tbl[17] = mk(0, 0, 32'h0,   '0,  0, 0, 32'h0,   32'h0, 0, 1, 1, VWR);

    rst_n = 1'b0; start = 1'b0; is_store = 1'b0;
    base_addr = '0; vec_wdata = '0; mem_ack = 1'b0;

    // Reset state
    tick(); tick();
    #4;
    chk("rst mem_req", mem_req, 0);
    chk("rst stall", stall, 0);
    chk("rst vreg_we", vreg_we, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst vec_rdata", vec_rdata, 0);
    chk("rst mem_addr", mem_addr, 0);

    // Table: mem_ack tied high
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i != 0) tick();
      start = tbl[i].st; is_store = tbl[i].str;
      base_addr = tbl[i].base; vec_wdata = tbl[i].wd;
      #4;
      chk($sformatf("row%0d mem_req", i),   mem_req,   tbl[i].e_req);
      chk($sformatf("row%0d mem_we", i),    mem_we,    tbl[i].e_we);
      chk($sformatf("row%0d mem_addr", i),  mem_addr,  tbl[i].e_addr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata, tbl[i].e_mwd);
      chk($sformatf("row%0d stall", i),     stall,     tbl[i].e_stall);
      chk($sformatf("row%0d vreg_we", i),   vreg_we,   tbl[i].e_vwe);
      chk($sformatf("row%0d done", i),      done,      tbl[i].e_done);
      chk($sformatf("row%0d err", i),       err,       0);
      chk($sformatf("row%0d vec_rdata", i), vec_rdata, tbl[i].e_vr);
    end

    // Wait states: store, each lane acked after 3 wait cycles, start pulses ignored
    tick();
    start = 1'b1; is_store = 1'b1; base_addr = 32'h300; vec_wdata = WWS; mem_ack = 1'b0;
    #4;
    chk("ws start stall", stall, 1);
    chk("ws start mem_req", mem_req, 0);
    for (int c = 1; c <= 16; c++) begin
      int lane;
      lane = (c - 1) / 4;
      tick();
      start = c[0]; is_store = 1'b0; base_addr = 32'h400; vec_wdata = '1;
      mem_ack = (((c - 1) % 4) == 3);
      #4;
      chk($sformatf("ws c%0d mem_req", c),   mem_req,   1);
      chk($sformatf("ws c%0d mem_we", c),    mem_we,    1);
      chk($sformatf("ws c%0d mem_addr", c),  mem_addr,  32'h300 + 32'(4 * lane));
      chk($sformatf("ws c%0d mem_wdata", c), mem_wdata, 32'hA0A0A0A0 + 32'(lane));
      chk($sformatf("ws c%0d stall", c),     stall,     1);
      chk($sformatf("ws c%0d done", c),      done,      0);
    end
    tick();
    start = 1'b1; mem_ack = 1'b1;
    #4;
    chk("ws c17 done", done, 1);
    chk("ws c17 vreg_we", vreg_we, 0);
    chk("ws c17 stall", stall, 0);
    chk("ws c17 mem_req", mem_req, 0);
    tick();
    start = 1'b0; mem_ack = 1'b0;
    #4;
    chk("ws c18 mem_req", mem_req, 0);
    chk("ws c18 stall", stall, 0);
    chk("ws c18 done", done, 0);
    chk("ws vec_rdata held", vec_rdata, VWR);

    // Reset mid-transfer after the lane-1 ack
    tick();
    start = 1'b1; is_store = 1'b0; base_addr = 32'h100; vec_wdata = '0; mem_ack = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #4;
    chk("mr lane1 mem_addr", mem_addr, 32'h104);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #4;
    chk("mr mem_req", mem_req, 0);
    chk("mr stall", stall, 0);
    chk("mr vec_rdata", vec_rdata, 0);
    for (int c = 0; c < 8; c++) begin
      if (c != 0) tick();
      #4;
      chk($sformatf("mr c%0d vreg_we", c), vreg_we, 0);
      chk($sformatf("mr c%0d done", c), done, 0);
      if (c != 7) #1;
    end

`ifdef VMEM_TIMEOUT_EN
    // Timeout: mem_ack never asserted
    tick();
    start = 1'b1; is_store = 1'b0; base_addr = 32'h500; mem_ack = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start = 1'b0;
      #4;
      chk($sformatf("to c%0d mem_req", c), mem_req, 1);
      chk($sformatf("to c%0d err", c), err, 0);
    end
    tick();
    #4;
    chk("to c17 err", err, 1);
    chk("to c17 mem_req", mem_req, 0);
    chk("to c17 stall", stall, 0);
    chk("to c17 done", done, 0);
    chk("to c17 vreg_we", vreg_we, 0);
    tick();
    #4;
    chk("to c18 err", err, 0);
    chk("to c18 mem_req", mem_req, 0);
    chk("to c18 done", done, 0);
    // Subsequent transfer completes normally
    tick();
    start = 1'b1; base_addr = 32'h100; mem_ack = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
      #4;
      chk($sformatf("to2 c%0d mem_addr", c), mem_addr, 32'h100 + 32'(4 * (c - 1)));
    end
    tick();
    #4;
    chk("to2 done", done, 1);
    chk("to2 vreg_we", vreg_we, 1);
    chk("to2 vec_rdata", vec_rdata, V1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_mem_seq.md
Name: vec_mem_seq

Overview:
- Multi-cycle sequencer for vector memory instructions (vldr opcode 10110, vstr opcode 10111) on the SIMD AES core.
- Splits one 128-bit vector register transfer into LANES word accesses on the shared 32-bit data-memory port.
- Stalls the pipeline while the transfer runs, then issues a single vector register-file write strobe for loads.
- Sits between the decoder/execute stage and data memory.

Parameters:
- LANES, 4, number of word accesses per vector.
- LANE_W, 32, bits per lane and memory data width.
- ADDR_W, 32, address width.
- ADDR_STRIDE, 4, byte address increment between lanes.
- TIMEOUT_CYC, 16, maximum wait cycles for mem_ack per lane. Used only with VMEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  vector memory instruction present in execute.
- is_store  in  1  1 = vstr, 0 = vldr; sampled with start.
- base_addr  in  ADDR_W  lane-0 address from rs1; sampled with start.
- vec_wdata  in  LANES*LANE_W  store data from the vector register; sampled with start. Lane i is bits [i*LANE_W +: LANE_W].
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable; valid while mem_req=1.
- mem_addr  out  ADDR_W  current lane address.
- mem_wdata  out  LANE_W  current lane store data.
- mem_rdata  in  LANE_W  load data; valid in a cycle with mem_ack=1.
- mem_ack  in  1  access completes this cycle.
- stall  out  1  hold PC and pipeline registers.
- vreg_we  out  1  one-cycle vector register-file write strobe.
- vec_rdata  out  LANES*LANE_W  assembled load vector.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse. Tied to 0 without VMEM_TIMEOUT_EN.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE, lane counter 0. All outputs 0 including vec_rdata. Reset mid-transfer aborts with no vreg_we and no done; the latched store data is discarded.
- IDLE:
  - mem_req=0; stall = start (combinational) so the instruction is held in execute.
  - When start=1: latch is_store, base_addr and vec_wdata, clear the lane counter, go to XFER.
- XFER:
  - mem_req=1, mem_we = latched is_store, mem_addr = base + lane*ADDR_STRIDE (mod 2^ADDR_W, wrap permitted), mem_wdata = latched lane word.
  - mem_req and the address/data outputs stay stable until mem_ack.
  - On mem_ack: a load writes mem_rdata into vec_rdata lane[lane]; the lane counter increments.
  - After the ack for lane LANES-1: a load goes to WB, a store goes to FIN.
  - mem_ack while mem_req=0 is ignored.
- WB: vreg_we=1, done=1, mem_req=0, stall=0; vec_rdata is complete and held. Next state IDLE.
- FIN: done=1, stall=0, mem_req=0. Next state IDLE.
- stall=1 in XFER. It is 0 in WB/FIN so the pipeline advances in the same cycle as done.
- vec_rdata holds its value until the next load overwrites it lane by lane. Lanes not yet written retain their old value.
- start is ignored outside IDLE. A start in the cycle after WB/FIN is accepted normally (back-to-back transfers are allowed).
- Minimum latency with mem_ack tied high: LANES+1 cycles from the start cycle to done (start cycle, LANES XFER cycles, WB/FIN cycle).
- The block never asserts mem_req and vreg_we in the same cycle.

Optional Feature:
- Macro: VMEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on each lane request and on each ack, and increments every XFER cycle without mem_ack.
  - If it reaches TIMEOUT_CYC, the block drops mem_req, pulses err=1 for one cycle, returns to IDLE and deasserts stall.
  - No vreg_we and no done are issued on a timeout.
- Undefined: no counter; err is tied to 0; XFER waits indefinitely for mem_ack.

Test Plan:
- Load, mem_ack tied high, base_addr=0x100, memory words 0x11111111/0x22222222/0x33333333/0x44444444 at 0x100/0x104/0x108/0x10C:
  - mem_addr sequence 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
  - vreg_we and done high at cycle 5 (start=cycle 0).
  - vec_rdata = 0x44444444_33333333_22222222_11111111.
  - stall high in cycles 0-4, low in cycle 5.
- Store, vec_wdata = 0xDEADBEEF_CAFEBABE_01234567_89ABCDEF, base_addr=0x200:
  - mem_we=1 with writes 0x89ABCDEF@0x200, 0x01234567@0x204, 0xCAFEBABE@0x208, 0xDEADBEEF@0x20C.
  - done high with vreg_we=0.
- Wait states, mem_ack delayed 3 cycles per lane:
  - mem_addr/mem_wdata stable while waiting.
  - done arrives 1+4*4 = 17 cycles after start.
  - start pulses during the transfer are ignored.
- Wrap, base_addr=0xFFFFFFF8: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset mid-transfer: rst_n=0 after the lane-1 ack → next cycle mem_req=0, stall=0, vec_rdata=0; no vreg_we/done ever issued for that transfer.
- VMEM_TIMEOUT_EN defined, TIMEOUT_CYC=16, mem_ack never asserted:
  - err pulses once 16 cycles after the first request.
  - The block returns to IDLE with done=0 and vreg_we=0.
  - A subsequent transfer completes normally.
